// File: rtl/dht_bcd_formatter_pkg.sv
// Shared types and constants for the DHT reading to BCD formatter.
// State encoding, clamp defaults, BCD field layout and converter sizing.
package dht_bcd_formatter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV_H = 2'd1,
    ST_CONV_T = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int SAT_INT_DEF  = 99;
  localparam int SAT_DEC_DEF  = 9;
  localparam int CNV_BITS_DEF = 8;

  localparam int NIB_W      = 4;
  localparam int BCD_W      = 12;
  localparam int TENS_LSB   = 8;
  localparam int UNITS_LSB  = 4;
  localparam int TENTHS_LSB = 0;

  localparam int CNT_W = 3;

  function automatic logic [7:0] sat8(input logic [7:0] val, input logic [7:0] lim);
    return (val > lim) ? lim : val;
  endfunction

  function automatic logic [BCD_W-1:0] pack_bcd(input logic [NIB_W-1:0] tens,
                                                input logic [NIB_W-1:0] units,
                                                input logic [NIB_W-1:0] tenths);
    logic [BCD_W-1:0] res;
    res = '0;
    res[TENS_LSB   +: NIB_W] = tens;
    res[UNITS_LSB  +: NIB_W] = units;
    res[TENTHS_LSB +: NIB_W] = tenths;
    return res;
  endfunction

endpackage

// File: rtl/dht_bcd_formatter_bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one bit per clock.
// oDone flags the cycle whose edge completes the last iteration; oBcd then carries the result.
module bin2bcd_seq
  import dht_bcd_formatter_pkg::*;
#(
  parameter int BIN_W = 8
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic [BIN_W-1:0] iBin,
  output logic [BCD_W-1:0] oBcd,
  output logic             oDone
);

  logic [BIN_W-1:0] bin_q, bin_d, bin_step;
  logic [BCD_W-1:0] bcd_q, bcd_d, bcd_adj, bcd_step;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_W / NIB_W; i++) begin
      if (bcd_q[i*NIB_W +: NIB_W] >= 4'd5) begin
        bcd_adj[i*NIB_W +: NIB_W] = bcd_q[i*NIB_W +: NIB_W] + 4'd3;
      end
    end
    {bcd_step, bin_step} = {bcd_adj, bin_q} << 1;

    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    run_d = run_q;
    // A start wins over a finishing run so the converter can be re-armed back to back.
    if (iStart) begin
      bin_d = iBin;
      bcd_d = '0;
      cnt_d = CNT_W'(BIN_W - 1);
      run_d = 1'b1;
    end else if (run_q) begin
      bin_d = bin_step;
      bcd_d = bcd_step;
      cnt_d = cnt_q - 1'b1;
      run_d = (cnt_q != '0);
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign oBcd  = bcd_step;
  assign oDone = run_q && (cnt_q == '0);

endmodule

// File: rtl/dht_bcd_formatter.sv
// Captures a DHT reading, clamps it, converts both integer bytes to BCD and presents packed digits.
// Optional temperature min/max tracking is built when DHT_MINMAX_EN is defined.
//
// state   | meaning
// IDLE    | waiting for iDone; captures clamped bytes and starts humidity conversion
// CONV_H  | converter running on humidity integer
// CONV_T  | converter running on temperature integer
// DONE    | publish BCD outputs, overflow and valid pulse
module dht_bcd_formatter
  import dht_bcd_formatter_pkg::*;
#(
  parameter int SAT_INT  = SAT_INT_DEF,
  parameter int SAT_DEC  = SAT_DEC_DEF,
  parameter int CNV_BITS = CNV_BITS_DEF
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iDone,
  input  logic [7:0]        iHumid_Int,
  input  logic [7:0]        iHumid_Dec,
  input  logic [7:0]        iTemp_Int,
  input  logic [7:0]        iTemp_Dec,
  output logic [BCD_W-1:0]  oHumid_Bcd,
  output logic [BCD_W-1:0]  oTemp_Bcd,
  output logic              oValid,
  output logic              oBusy,
  output logic              oOvr,
  output logic [BCD_W-1:0]  oTemp_Min_Bcd,
  output logic [BCD_W-1:0]  oTemp_Max_Bcd
);

  localparam logic [7:0] SAT_INT_B = 8'(SAT_INT);
  localparam logic [7:0] SAT_DEC_B = 8'(SAT_DEC);

  state_e           state_q, state_d;
  logic [7:0]       t_int_q, t_int_d;
  logic [3:0]       h_dec_q, h_dec_d, t_dec_q, t_dec_d;
  logic             ovr_pend_q, ovr_pend_d;
  logic [7:0]       h_tu_q, h_tu_d, t_tu_q, t_tu_d;
  logic [BCD_W-1:0] humid_bcd_q, humid_bcd_d, temp_bcd_q, temp_bcd_d;
  logic             valid_q, valid_d, busy_q, busy_d, ovr_q, ovr_d;

  logic [7:0]          sat_h_int, sat_t_int, sat_h_dec, sat_t_dec;
  logic                clamp_any;
  logic                cnv_start, cnv_done;
  logic [CNV_BITS-1:0] cnv_op;
  logic [BCD_W-1:0]    cnv_bcd;
  logic                unused_hundreds;

  bin2bcd_seq #(.BIN_W(CNV_BITS)) u_cnv (
    .iClk   (iClk),
    .iRst   (iRst),
    .iStart (cnv_start),
    .iBin   (cnv_op),
    .oBcd   (cnv_bcd),
    .oDone  (cnv_done)
  );

  // Hundreds digit is always zero once inputs are clamped to 99.
  assign unused_hundreds = ^cnv_bcd[BCD_W-1:8];

  always_comb begin
    sat_h_int = sat8(iHumid_Int, SAT_INT_B);
    sat_t_int = sat8(iTemp_Int,  SAT_INT_B);
    sat_h_dec = sat8(iHumid_Dec, SAT_DEC_B);
    sat_t_dec = sat8(iTemp_Dec,  SAT_DEC_B);
    clamp_any = (iHumid_Int > SAT_INT_B) || (iTemp_Int > SAT_INT_B) ||
                (iHumid_Dec > SAT_DEC_B) || (iTemp_Dec > SAT_DEC_B);

    state_d     = state_q;
    t_int_d     = t_int_q;
    h_dec_d     = h_dec_q;
    t_dec_d     = t_dec_q;
    ovr_pend_d  = ovr_pend_q;
    h_tu_d      = h_tu_q;
    t_tu_d      = t_tu_q;
    humid_bcd_d = humid_bcd_q;
    temp_bcd_d  = temp_bcd_q;
    valid_d     = 1'b0;
    busy_d      = busy_q;
    ovr_d       = ovr_q;
    cnv_start   = 1'b0;
    cnv_op      = CNV_BITS'(sat_h_int);

    case (state_q)
      ST_IDLE: begin
        // The cycle right after a publish is still blocked so a stale done cannot retrigger.
        if (iDone && !valid_q) begin
          t_int_d    = sat_t_int;
          h_dec_d    = sat_h_dec[3:0];
          t_dec_d    = sat_t_dec[3:0];
          ovr_pend_d = clamp_any;
          cnv_start  = 1'b1;
          busy_d     = 1'b1;
          state_d    = ST_CONV_H;
        end
      end
      ST_CONV_H: begin
        if (cnv_done) begin
          h_tu_d    = cnv_bcd[7:0];
          cnv_start = 1'b1;
          cnv_op    = CNV_BITS'(t_int_q);
          state_d   = ST_CONV_T;
        end
      end
      ST_CONV_T: begin
        if (cnv_done) begin
          t_tu_d  = cnv_bcd[7:0];
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        humid_bcd_d = pack_bcd(h_tu_q[7:4], h_tu_q[3:0], h_dec_q);
        temp_bcd_d  = pack_bcd(t_tu_q[7:4], t_tu_q[3:0], t_dec_q);
        ovr_d       = ovr_pend_q;
        valid_d     = 1'b1;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q     <= ST_IDLE;
      t_int_q     <= '0;
      h_dec_q     <= '0;
      t_dec_q     <= '0;
      ovr_pend_q  <= 1'b0;
      h_tu_q      <= '0;
      t_tu_q      <= '0;
      humid_bcd_q <= '0;
      temp_bcd_q  <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_int_q     <= t_int_d;
      h_dec_q     <= h_dec_d;
      t_dec_q     <= t_dec_d;
      ovr_pend_q  <= ovr_pend_d;
      h_tu_q      <= h_tu_d;
      t_tu_q      <= t_tu_d;
      humid_bcd_q <= humid_bcd_d;
      temp_bcd_q  <= temp_bcd_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      ovr_q       <= ovr_d;
    end
  end

  assign oHumid_Bcd = humid_bcd_q;
  assign oTemp_Bcd  = temp_bcd_q;
  assign oValid     = valid_q;
  assign oBusy      = busy_q;
  assign oOvr       = ovr_q;

`ifdef DHT_MINMAX_EN
  logic [11:0]      mm_key;
  logic [11:0]      min_key_q, min_key_d, max_key_q, max_key_d;
  logic [BCD_W-1:0] min_bcd_q, min_bcd_d, max_bcd_q, max_bcd_d;
  logic             mm_init_q, mm_init_d;

  always_comb begin
    mm_key    = {t_int_q, t_dec_q};
    min_key_d = min_key_q;
    max_key_d = max_key_q;
    min_bcd_d = min_bcd_q;
    max_bcd_d = max_bcd_q;
    mm_init_d = mm_init_q;
    if (state_q == ST_DONE) begin
      if (!mm_init_q || (mm_key < min_key_q)) begin
        min_key_d = mm_key;
        min_bcd_d = temp_bcd_d;
      end
      if (!mm_init_q || (mm_key > max_key_q)) begin
        max_key_d = mm_key;
        max_bcd_d = temp_bcd_d;
      end
      mm_init_d = 1'b1;
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      min_key_q <= '0;
      max_key_q <= '0;
      min_bcd_q <= '0;
      max_bcd_q <= '0;
      mm_init_q <= 1'b0;
    end else begin
      min_key_q <= min_key_d;
      max_key_q <= max_key_d;
      min_bcd_q <= min_bcd_d;
      max_bcd_q <= max_bcd_d;
      mm_init_q <= mm_init_d;
    end
  end

  assign oTemp_Min_Bcd = min_bcd_q;
  assign oTemp_Max_Bcd = max_bcd_q;
`else
  assign oTemp_Min_Bcd = '0;
  assign oTemp_Max_Bcd = '0;
`endif

endmodule

// File: tb/tb_dht_bcd_formatter.sv
// Directed bench for dht_bcd_formatter: latency, clamping, busy rejection, reset abort, hold, min/max.
// Build with DHT_MINMAX_EN defined to exercise the min/max tracking outputs.
module tb_dht_bcd_formatter;

  logic        iClk = 1'b0;
  logic        iRst = 1'b0;
  logic        iDone = 1'b0;
  logic [7:0]  iHumid_Int = '0, iHumid_Dec = '0, iTemp_Int = '0, iTemp_Dec = '0;
  logic [11:0] oHumid_Bcd, oTemp_Bcd, oTemp_Min_Bcd, oTemp_Max_Bcd;
  logic        oValid, oBusy, oOvr;

  int n_checks = 0;
  int n_err    = 0;
  int valid_cnt = 0;
  int lat;
  int vc0;

  dht_bcd_formatter dut (
    .iClk          (iClk),
    .iRst          (iRst),
    .iDone         (iDone),
    .iHumid_Int    (iHumid_Int),
    .iHumid_Dec    (iHumid_Dec),
    .iTemp_Int     (iTemp_Int),
    .iTemp_Dec     (iTemp_Dec),
    .oHumid_Bcd    (oHumid_Bcd),
    .oTemp_Bcd     (oTemp_Bcd),
    .oValid        (oValid),
    .oBusy         (oBusy),
    .oOvr          (oOvr),
    .oTemp_Min_Bcd (oTemp_Min_Bcd),
    .oTemp_Max_Bcd (oTemp_Max_Bcd)
  );

  always #5 iClk = ~iClk;

  always @(negedge iClk) if (oValid) valid_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic set_bytes(input logic [7:0] hi, input logic [7:0] hd,
                           input logic [7:0] ti, input logic [7:0] td);
    iHumid_Int = hi;
    iHumid_Dec = hd;
    iTemp_Int  = ti;
    iTemp_Dec  = td;
  endtask

  task automatic start(input logic [7:0] hi, input logic [7:0] hd,
                       input logic [7:0] ti, input logic [7:0] td);
    set_bytes(hi, hd, ti, td);
    iDone = 1'b1;
    tick();
    iDone = 1'b0;
  endtask

  // Counts edges after the capture edge until oValid is seen; -1 if it never comes.
  task automatic wait_valid(output int edges);
    edges = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (oValid) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic reading(input string tag,
                         input logic [7:0] hi, input logic [7:0] hd,
                         input logic [7:0] ti, input logic [7:0] td,
                         input logic [11:0] exp_h, input logic [11:0] exp_t, input logic exp_o);
    int e;
    start(hi, hd, ti, td);
    check_eq({tag, "_busy"}, 32'(oBusy), 32'd1);
    wait_valid(e);
    check_eq({tag, "_lat"}, e, 17);
    check_eq({tag, "_humid"}, 32'(oHumid_Bcd), 32'(exp_h));
    check_eq({tag, "_temp"}, 32'(oTemp_Bcd), 32'(exp_t));
    check_eq({tag, "_ovr"}, 32'(oOvr), 32'(exp_o));
    tick();
    check_eq({tag, "_pulse"}, {30'd0, oValid, oBusy}, 32'd0);
  endtask

  initial begin
    // reset state
    repeat (3) tick();
    check_eq("rst_humid", 32'(oHumid_Bcd), 32'h0);
    check_eq("rst_temp", 32'(oTemp_Bcd), 32'h0);
    check_eq("rst_flags", {29'd0, oValid, oBusy, oOvr}, 32'd0);
    iRst = 1'b1;
    repeat (2) tick();

    // 1: basic reading
    reading("t1", 8'd55, 8'd0, 8'd27, 8'd3, 12'h550, 12'h273, 1'b0);

    // 5: outputs hold while idle
    vc0 = valid_cnt;
    repeat (1000) tick();
    check_eq("hold_humid", 32'(oHumid_Bcd), 32'h550);
    check_eq("hold_temp", 32'(oTemp_Bcd), 32'h273);
    check_eq("hold_novalid", valid_cnt - vc0, 0);

    // 2: clamping then overflow cleared
    reading("t2a", 8'd150, 8'd12, 8'd0, 8'd0, 12'h999, 12'h000, 1'b1);
    reading("t2b", 8'd40, 8'd0, 8'd20, 8'd0, 12'h400, 12'h200, 1'b0);
    reading("t2c", 8'd99, 8'd9, 8'd100, 8'd0, 12'h999, 12'h990, 1'b1);

    // 3: second iDone while busy is ignored
    vc0 = valid_cnt;
    start(8'd60, 8'd0, 8'd25, 8'd0);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (i == 5) begin
        set_bytes(8'd10, 8'd0, 8'd10, 8'd0);
        iDone = 1'b1;
      end
      tick();
      iDone = 1'b0;
      if (oValid) begin
        lat = i;
        break;
      end
    end
    check_eq("t3_lat", lat, 17);
    check_eq("t3_humid", 32'(oHumid_Bcd), 32'h600);
    check_eq("t3_temp", 32'(oTemp_Bcd), 32'h250);
    // iDone during the valid cycle must also be ignored
    set_bytes(8'd11, 8'd0, 8'd11, 8'd0);
    iDone = 1'b1;
    tick();
    iDone = 1'b0;
    check_eq("t3_busy_after", 32'(oBusy), 32'd0);
    repeat (25) tick();
    check_eq("t3_one_valid", valid_cnt - vc0, 1);
    check_eq("t3_humid_kept", 32'(oHumid_Bcd), 32'h600);

    // 4: reset mid-conversion aborts
    vc0 = valid_cnt;
    start(8'd70, 8'd0, 8'd80, 8'd0);
    repeat (7) tick();
    iRst = 1'b0;
    #1;
    check_eq("t4_humid0", 32'(oHumid_Bcd), 32'h0);
    check_eq("t4_temp0", 32'(oTemp_Bcd), 32'h0);
    check_eq("t4_busy0", 32'(oBusy), 32'd0);
    repeat (3) tick();
    iRst = 1'b1;
    repeat (25) tick();
    check_eq("t4_novalid", valid_cnt - vc0, 0);
    reading("t4b", 8'd33, 8'd3, 8'd22, 8'd2, 12'h333, 12'h222, 1'b0);

    // 6: min/max tracking (first reading after reset was 22.2)
    reading("t6a", 8'd50, 8'd0, 8'd25, 8'd0, 12'h500, 12'h250, 1'b0);
    reading("t6b", 8'd50, 8'd0, 8'd30, 8'd5, 12'h500, 12'h305, 1'b0);
    reading("t6c", 8'd50, 8'd0, 8'd20, 8'd1, 12'h500, 12'h201, 1'b0);
`ifdef DHT_MINMAX_EN
    check_eq("t6_min", 32'(oTemp_Min_Bcd), 32'h201);
    check_eq("t6_max", 32'(oTemp_Max_Bcd), 32'h305);
`else
    check_eq("t6_min", 32'(oTemp_Min_Bcd), 32'h0);
    check_eq("t6_max", 32'(oTemp_Max_Bcd), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/dht_bcd_formatter.md
Name: dht_bcd_formatter

Overview:
Downstream consumer of the DHT controller's four reading bytes and its one-cycle done pulse.
- Captures one completed reading.
- Saturates it to display range.
- Converts the integer bytes to BCD with a sequential shift-add-3 engine.
- Presents registered, packed BCD (tens/units/tenths) for humidity and temperature to the FND display mux, with a valid pulse and an overflow flag.

Parameters:
SAT_INT, 99, clamp ceiling for integer bytes (range 0..99).
SAT_DEC, 9, clamp ceiling for decimal bytes (range 0..9).
CNV_BITS, 8, binary operand width fed to the converter.

Ports:
iClk  input  1  system clock
iRst  input  1  reset, asynchronous, active-low (0 = reset)
iDone  input  1  one-cycle pulse from DHT controller: reading bytes valid this cycle
iHumid_Int  input  8  humidity integer byte
iHumid_Dec  input  8  humidity decimal byte
iTemp_Int  input  8  temperature integer byte
iTemp_Dec  input  8  temperature decimal byte
oHumid_Bcd  output  12  [11:8] tens, [7:4] units, [3:0] tenths
oTemp_Bcd  output  12  same packing as oHumid_Bcd
oValid  output  1  one-cycle pulse: both BCD outputs updated this cycle
oBusy  output  1  high while a capture is being converted
oOvr  output  1  any byte of the last accepted reading was clamped
oTemp_Min_Bcd  output  12  optional-feature output, see below
oTemp_Max_Bcd  output  12  optional-feature output, see below

Behaviour:
- Reset (iRst=0, asynchronous): state IDLE; all capture registers, BCD outputs, oValid, oBusy, oOvr and min/max registers = 0.
- States:
  - IDLE: oBusy=0. iDone=1 at edge E0 captures the four bytes, clamped, and sets oOvr_next. Moves to CONV_H; oBusy=1 from E0.
  - CONV_H: shift counter 0..7. One iteration per edge E1..E8. Each iteration first adds 3 to each BCD nibble >=5, then shifts {bcd, bin} left by 1. At E8 the result is latched and the state moves to CONV_T.
  - CONV_T: same procedure on the temperature integer, edges E9..E16, then moves to DONE.
  - DONE: at E17 the following register together:
    - oHumid_Bcd = {tens, units, clampedHumidDec[3:0]}
    - oTemp_Bcd = {tens, units, clampedTempDec[3:0]}
    - oOvr
  - Also at E17: oValid=1 for exactly one cycle, oBusy=0, return to IDLE.
- Latency: oValid is high in the cycle starting 17 clock edges after the edge that sampled iDone.
- Clamp rules:
  - An integer byte >SAT_INT becomes SAT_INT.
  - A decimal byte >SAT_DEC becomes SAT_DEC.
  - oOvr = OR of the four clamp events and is updated only at E17.
- The converter hundreds nibble is always 0 after clamping and is discarded. The internal converter is 12 bits wide.
- iDone while oBusy=1 (including the DONE cycle) is ignored. The in-flight conversion completes unchanged.
- iDone coincident with the E17 oValid cycle is ignored. A new capture requires iDone in IDLE.
- Outputs hold their last values between oValid pulses. There is no auto-clear.
- Reset mid-conversion aborts immediately: no oValid, outputs return to 0.

Optional Feature:
Macro DHT_MINMAX_EN.
- Defined:
  - oTemp_Min_Bcd and oTemp_Max_Bcd track the extreme clamped temperature.
  - Comparison key = {int, dec}, binary.
  - They update at E17 alongside oTemp_Bcd.
  - The first oValid after reset initialises both to the current reading.
  - Both are cleared by reset only.
- Undefined: both ports are driven constant 0 and no compare logic or registers are built.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, CONV_H, CONV_T, DONE)
  - SAT_INT/SAT_DEC defaults
  - BCD nibble width (4) and packed digit field offsets
  - shift-count width (3)
- One natural sub-module: bin2bcd_seq. It takes an 8-bit operand and a start strobe, runs 8 shift-add-3 iterations, and returns a 12-bit BCD value with a done strobe. It is instantiated once and time-shared between humidity and temperature.

Test Plan:
1. Reset release, then iDone with H=55.0, T=27.3 -> 17 edges later oValid=1 for one cycle, oHumid_Bcd=12'h550, oTemp_Bcd=12'h273, oOvr=0.
2. iDone with H=150, Hdec=12, T=0.0 -> oHumid_Bcd=12'h999, oTemp_Bcd=12'h000, oOvr=1. The next reading, 40.0/20.0, clears oOvr to 0.
3. iDone with 60.0/25.0, then a second iDone 5 cycles later with 10.0/10.0 -> exactly one oValid, outputs 12'h600/12'h250, oBusy low after 17 edges.
4. iRst=0 asserted 8 cycles after iDone -> outputs immediately 0, oBusy=0, no oValid follows. A subsequent iDone with 33.3/22.2 yields 12'h333/12'h222.
5. Outputs hold: after test 1, run 1000 idle cycles -> oHumid_Bcd stays 12'h550, oValid stays 0.
6. With DHT_MINMAX_EN, temperature sequence 25.0, 30.5, 20.1 -> after the third oValid, oTemp_Min_Bcd=12'h201, oTemp_Max_Bcd=12'h305. Without the macro, both stay 0.
